// File: rtl/max7219_pkg.sv
// Shared types and constants for the MAX7219 daisy-chain serializer.
// Build option: MAX7219_CHAIN_CHECK_EN (see max7219_chain.sv).
package max7219_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_e;

    localparam logic [15:0] MAX7219_NOP = 16'h0000;

    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    // Builds a 16-bit device word: {don't-care nibble, address, value}.
    function automatic logic [15:0] max7219_word(input logic [3:0] addr, input logic [7:0] val);
        return {4'h0, addr, val};
    endfunction

endpackage

// File: rtl/max7219_bitclk.sv
// SCLK generator: CLK_PER_SCLK divider with enable, idles low, and
// combinational strobes flagging the clk edge on which sclk rises or falls.
module max7219_bitclk #(
    parameter int unsigned CLK_PER_SCLK = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    import max7219_pkg::*;

    localparam int unsigned HALF = CLK_PER_SCLK / 2;
    localparam int unsigned CW   = $clog2(CLK_PER_SCLK);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    assign rise = en && (cnt_q == '0);
    assign fall = en && (cnt_q == CW'(HALF));
    assign sclk = sclk_q;

    always_comb begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (en) begin
            cnt_d = (cnt_q == CW'(CLK_PER_SCLK - 1)) ? '0 : cnt_q + 1'b1;
            if (rise) begin
                sclk_d = 1'b1;
            end else if (fall) begin
                sclk_d = 1'b0;
            end else begin
                sclk_d = sclk_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/max7219_chain.sv
// SPI frame serializer for a daisy chain of NDEV MAX7219 drivers, one frame per CS-low window.
// Build option MAX7219_CHAIN_CHECK_EN adds chain_in/chain_err/chain_vld loop-back checking.
module max7219_chain #(
    parameter int unsigned NDEV                       = 4,
    parameter int unsigned DATABITS                   = 16,
    parameter int unsigned CLK_PER_SCLK               = 100,
    parameter int unsigned CS_FALL_TO_FIRST_SCLK_RISE = 1000,
    parameter int unsigned LAST_SCLK_FALL_TO_CS_RISE  = 1000,
    parameter int unsigned CS_HIGH_MIN                = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NDEV*DATABITS-1:0] data,
    input  logic [NDEV-1:0]          mask,
`ifdef MAX7219_CHAIN_CHECK_EN
    input  logic                     chain_in,
    output logic                     chain_err,
    output logic                     chain_vld,
`endif
    output logic                     cs,
    output logic                     sclk,
    output logic                     dout,
    output logic                     busy,
    output logic                     done
);
    import max7219_pkg::*;

    localparam int unsigned NBITS    = NDEV * DATABITS;
    localparam int unsigned HALF     = CLK_PER_SCLK / 2;
    // HOLD is entered on the last falling edge, so it also covers the final low half period.
    localparam int unsigned HOLD_CYC = HALF + LAST_SCLK_FALL_TO_CS_RISE;
    localparam int unsigned MAX_AB   = (CS_FALL_TO_FIRST_SCLK_RISE > HOLD_CYC) ?
                                       CS_FALL_TO_FIRST_SCLK_RISE : HOLD_CYC;
    localparam int unsigned CNT_MAX  = (MAX_AB > CS_HIGH_MIN) ? MAX_AB : CS_HIGH_MIN;
    localparam int unsigned CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BW       = $clog2(NBITS + 1);

    if (NDEV < 1 || DATABITS < 1 || CLK_PER_SCLK < 2 || (CLK_PER_SCLK % 2) != 0 ||
        CS_FALL_TO_FIRST_SCLK_RISE < 1 || LAST_SCLK_FALL_TO_CS_RISE < 1 || CS_HIGH_MIN < 1)
    begin : g_param_err
        $error("max7219_chain: illegal parameter values");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]  shreg_q, shreg_d;
    logic              cs_q, cs_d;
    logic              dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NBITS-1:0]  frame;
    logic              bclk_en, bclk_rise, bclk_fall;

    always_comb begin
        frame = '0;
        for (int unsigned i = 0; i < NDEV; i++) begin
            frame[i*DATABITS +: DATABITS] = mask[i] ? data[i*DATABITS +: DATABITS]
                                                    : DATABITS'(MAX7219_NOP);
        end
    end

    assign bclk_en = (state_q == SHIFT) || (state_q == SETUP && cnt_q == '0);

    max7219_bitclk #(
        .CLK_PER_SCLK(CLK_PER_SCLK)
    ) u_bitclk (
        .clk  (clk),
        .rst  (rst),
        .en   (bclk_en),
        .sclk (sclk),
        .rise (bclk_rise),
        .fall (bclk_fall)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        cs_d      = cs_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = frame;
                    dout_d    = frame[NBITS-1];
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(CS_FALL_TO_FIRST_SCLK_RISE - 1);
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (bclk_fall) begin
                    shreg_d   = shreg_q << 1;
                    dout_d    = shreg_d[NBITS-1];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(NBITS - 1)) begin
                        cnt_d   = CW'(HOLD_CYC - 1);
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cs_d    = 1'b1;
                    dout_d  = 1'b0;
                    cnt_d   = CW'(CS_HIGH_MIN - 1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            cs_q      <= 1'b1;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            cs_q      <= cs_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cs   = cs_q;
    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef MAX7219_CHAIN_CHECK_EN
    // cur holds this frame's post-mask bits; prev is what the chain should echo back next frame.
    logic [NBITS-1:0] cap_q, cap_d, cur_q, cur_d, prev_q, prev_d;
    logic             err_q, err_d, vld_q, vld_d, seen_q, seen_d;

    always_comb begin
        cap_d  = bclk_rise ? ((cap_q << 1) | NBITS'(chain_in)) : cap_q;
        cur_d  = (state_q == IDLE && start) ? frame : cur_q;
        prev_d = prev_q;
        err_d  = err_q;
        vld_d  = vld_q;
        seen_d = seen_q;
        if (done_d) begin
            err_d  = (cap_q != prev_q);
            vld_d  = seen_q;
            prev_d = cur_q;
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q  <= '0;
            cur_q  <= '0;
            prev_q <= '0;
            err_q  <= 1'b0;
            vld_q  <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            cap_q  <= cap_d;
            cur_q  <= cur_d;
            prev_q <= prev_d;
            err_q  <= err_d;
            vld_q  <= vld_d;
            seen_q <= seen_d;
        end
    end

    assign chain_err = err_q;
    assign chain_vld = vld_q;
`endif

endmodule
